// File: rtl/mem_bus_initiator_pkg.sv
// Shared types and widths for the MEM-stage data-bus initiator.
// - DataWidth/AddrWidth/SelWidth: data bus, byte address and byte-enable widths.
// - mbi_state_e: 3-bit FSM state encoding.
// - word_align(): clears the byte offset of an address.
package mem_bus_initiator_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned SelWidth  = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } mbi_state_e;

  function automatic logic [AddrWidth-1:0] word_align(input logic [AddrWidth-1:0] addr);
    return addr & ~AddrWidth'(3);
  endfunction

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Valid/ready data bus between the MEM-stage initiator and the data RAM responder.
// - master: drives bus_req_* and receives bus_req_ready plus the one-cycle response.
// - slave : the responder's view.
interface mem_bus_initiator_if;
  import mem_bus_initiator_pkg::*;

  logic                 bus_req_valid;
  logic                 bus_req_ready;
  logic                 bus_req_write;
  logic [AddrWidth-1:0] bus_req_addr;
  logic [SelWidth-1:0]  bus_req_sel;
  logic [DataWidth-1:0] bus_req_wdata;
  logic                 bus_resp_valid;
  logic [DataWidth-1:0] bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_sel, bus_req_wdata,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_sel, bus_req_wdata,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

endinterface

// File: rtl/mem_bus_initiator.sv
// MEM-stage data-bus master. Converts a pending load/store into one valid/ready bus
// transaction, stalls the pipeline until the response returns and holds the last read word
// for MEMWB.
// Ports:
// - clk, rst                  : core clock, synchronous active-high reset
// - stall_current_stage, flush: external MEM stall and instruction kill
// - mem_read_flag/mem_write_flag, mem_sel, mem_addr, mem_write_data: MEM-stage request
// - bus                       : request/response bus (master side)
// - stall_request             : hold IF..MEM while the access is outstanding
// - ram_read_data             : last completed read word
// - bus_error                 : one-cycle pulse on the first DONE cycle after a timeout
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_current_stage,
  input  logic                 flush,
  input  logic                 mem_read_flag,
  input  logic                 mem_write_flag,
  input  logic [SelWidth-1:0]  mem_sel,
  input  logic [AddrWidth-1:0] mem_addr,
  input  logic [DataWidth-1:0] mem_write_data,
  mem_bus_initiator_if.master  bus,
  output logic                 stall_request,
  output logic [DataWidth-1:0] ram_read_data,
  output logic                 bus_error
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  mbi_state_e           state_q, state_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [SelWidth-1:0]  sel_q, sel_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic access;
  logic timeout;

  assign access  = (mem_read_flag | mem_write_flag) & ~flush;
  assign timeout = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Request registers only load here, so they stay frozen for the whole REQ phase.
        if (access) begin
          write_d = mem_write_flag;
          addr_d  = word_align(mem_addr);
          sel_d   = mem_sel;
          wdata_d = mem_write_data;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.bus_req_ready) begin
          // An accepted request cannot be withdrawn; a concurrent flush must drain it.
          cnt_d   = '0;
          state_d = flush ? StDrain : StWait;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (flush) begin
          state_d = (bus.bus_resp_valid || timeout) ? StIdle : StDrain;
        end else if (bus.bus_resp_valid) begin
          if (!write_q) rdata_d = bus.bus_resp_rdata;
          state_d = StDone;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDrain: begin
        // Counter keeps running from WAIT so a lost response cannot hang the drain.
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (bus.bus_resp_valid || timeout) state_d = StIdle;
      end
      StDone: begin
        // Hold here while externally stalled so the same access is not re-issued.
        if (!stall_current_stage || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_request = ((state_q == StIdle) && access) || (state_q == StReq) ||
                    (state_q == StWait) || ((state_q == StDrain) && access);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req_valid = (state_q == StReq);
  assign bus.bus_req_write = write_q;
  assign bus.bus_req_addr  = addr_q;
  assign bus.bus_req_sel   = sel_q;
  assign bus.bus_req_wdata = wdata_q;
  assign ram_read_data     = rdata_q;
  assign bus_error         = err_q;

endmodule
